mips_data_mem: RTL
==================

// Module: mips_data_mem
// PURPOSE
//  Responder end of the CPU data-memory port: word-organised big-endian RAM with per-byte write
//  enables and 1-cycle registered read data, matching the CPU's EX-issue / MEM-consume timing.
//  Also decodes a small MMIO window holding a cycle counter and a console TX FIFO that is drained
//  by an external valid/ready sink.
// PARAMETERS
//  ADDR_W     12             word-address bits of RAM (2^ADDR_W words, 16 KB default)
//  MMIO_BASE  32'hFFFF_0000  MMIO window, selected when mem_addr[31:16]==MMIO_BASE[31:16]
//  FIFO_DEPTH 8              console FIFO entries; power of two, >=2
// PORTS
//  clk            in   1   clock, rising edge
//  rst_n          in   1   asynchronous, active-low reset
//  en             in   1   global pipeline enable; 0 freezes the CPU-side state
//  mem_addr       in   32  byte address, valid in the CPU EX cycle
//  mem_read_en    in   1   read request
//  mem_write_en   in   4   byte write enables; [3]=bits 31:24 (byte addr 00) ... [0]=bits 7:0 (11)
//  mem_write_data in   32  write data, already lane-replicated by the CPU for sb/sh
//  mem_read_data  out  32  read data for the request of the previous enabled cycle
//  con_valid      out  1   console byte available
//  con_data       out  8   console byte (FIFO head)
//  con_ready      in   1   sink accepts con_data when con_valid & con_ready
// BEHAVIOUR
//  Reset: mem_read_data=0, cycle counter=0, drop counter=0, FIFO empty, con_valid=0. RAM not reset.
//  RAM index = mem_addr[ADDR_W+1:2]; upper bits ignored (aliasing); addr[1:0] never faults.
//  Write: on the edge where en & |mem_write_en & RAM-hit, update only the enabled lanes.
//  Read: on the edge where en & mem_read_en, register the selected word into mem_read_data
//   (latency 1). Otherwise mem_read_data holds. Same-cycle read+write to one word returns OLD data.
//  en=0: no RAM/MMIO write, no read capture, cycle counter frozen; console drain still runs.
//  MMIO offsets (mem_addr[3:2]):
//   0x0 CYCLE   RO  32-bit count of en=1 cycles, wraps at 2^32; writes ignored
//   0x4 STATUS  RO  {24'b0, count[3:0], 2'b0, empty, full}
//   0x8 CONDATA WO  any en & |mem_write_en pushes mem_write_data[7:0]; reads return 0
//   0xC DROPS   RW  saturating 32-bit count of pushes refused while full; any write clears it to 0
//  FIFO: pop when con_valid & con_ready. Push+pop in the same cycle while full: both are taken,
//   no drop. Push while empty: con_valid rises the next cycle (no fall-through).
//   con_data is stable while con_valid & ~con_ready.
//  MMIO reads use the same 1-cycle latency; STATUS/CYCLE are sampled at the request edge.
//  Reset asserted mid-transfer: the FIFO is emptied and con_valid drops asynchronously.
// CONFIGURATION
//  DMEM_CONSOLE_EN defined: console FIFO, STATUS, CONDATA and DROPS are implemented as above.
//  Undefined: con_valid=0, con_data=0; STATUS reads 32'h2 (empty); CONDATA writes are discarded;
//   DROPS reads 0. CYCLE and RAM are unchanged.
// STRUCTURE
//  mips_mem_defs.vh (shared include): MMIO offsets, STATUS bit positions, byte-lane
//   index localparams; reused by the CPU test harness.
//  Sub-module dmem_console_fifo: sync FIFO, push/pop/full/empty/count, async active-low reset.
//  RAM is a plain reg array with lane-sliced writes, inferable as block RAM.
// TESTING
//  sw 0x11223344 @0x100, then lw @0x100 -> mem_read_data=0x11223344 exactly one edge after request.
//  sb 0xAA (data 0xAAAAAAAA, we=4'b0100) @0x101 over 0x11223344 -> lw returns 0x11AA3344.
//  en=0 for 5 cycles with we=4'hF -> RAM unchanged, CYCLE delta excludes those 5 cycles.
//  Push 9 bytes into DEPTH-8 FIFO with con_ready=0 -> STATUS full=1, count=8, DROPS=1;
//   write DROPS -> DROPS reads 0.
//  Full FIFO, con_ready=1 and push 0x5A in the same cycle -> no drop, 0x5A becomes the 8th entry.
//  rst_n low mid-drain -> con_valid=0 immediately, mem_read_data=0; after release STATUS=0x2.

Source files
------------

// File: rtl/mips_data_mem_pkg.sv
// Shared definitions for the MIPS data-memory responder: MMIO register map,
// STATUS bit positions, byte-lane numbering and the STATUS word builder.
package mips_data_mem_pkg;

   // Register select inside the MMIO window, taken from mem_addr[3:2]
   typedef enum logic [1:0] {
      MMIO_CYCLE   = 2'd0,
      MMIO_STATUS  = 2'd1,
      MMIO_CONDATA = 2'd2,
      MMIO_DROPS   = 2'd3
   } mmio_reg_e;

   // STATUS layout: {24'b0, count[3:0], 2'b0, empty, full}
   localparam int STATUS_FULL_BIT  = 0;
   localparam int STATUS_EMPTY_BIT = 1;
   localparam int STATUS_COUNT_LSB = 4;
   localparam int STATUS_COUNT_W   = 4;

   // STATUS value seen when the console is not built: permanently empty
   localparam logic [31:0] STATUS_NO_CONSOLE = 32'h0000_0002;

   // Big-endian lane numbering: byte address 00 lives in bits 31:24 (we[3])
   localparam int LANE_BYTE_ADDR_0 = 3;
   localparam int LANE_BYTE_ADDR_1 = 2;
   localparam int LANE_BYTE_ADDR_2 = 1;
   localparam int LANE_BYTE_ADDR_3 = 0;

   function automatic logic [31:0] status_word(input logic [STATUS_COUNT_W-1:0] count,
                                               input logic empty,
                                               input logic full);
      logic [31:0] w;
      w = '0;
      w[STATUS_COUNT_LSB +: STATUS_COUNT_W] = count;
      w[STATUS_EMPTY_BIT] = empty;
      w[STATUS_FULL_BIT]  = full;
      return w;
   endfunction

endpackage

// File: rtl/mips_data_mem_console_fifo.sv
// dmem_console_fifo: synchronous FIFO feeding the console TX sink.
// Only present when DMEM_CONSOLE_EN is defined; a push into a full FIFO is
// still accepted when a pop happens on the same edge.
`ifdef DMEM_CONSOLE_EN
module dmem_console_fifo
   import mips_data_mem_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int DATA_W = 8,
   parameter int CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] pop_data,
   output logic              full,
   output logic              empty,
   output logic [CNT_W-1:0]  count
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [DATA_W-1:0] store [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              push_ok;
   logic              pop_ok;

   assign full     = (count == CNT_W'(DEPTH));
   assign empty    = (count == '0);
   assign pop_ok   = pop & ~empty;
   assign push_ok  = push & (~full | pop_ok);
   assign pop_data = store[rd_ptr];

   // Entry storage; when full with push+pop the head is read out before the
   // tail write lands in the same slot.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         store[wr_ptr] <= push_data;
      end
   end

   // Pointers and occupancy count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule
`endif

// File: rtl/mips_data_mem.sv
// mips_data_mem: CPU data-memory responder. Big-endian word RAM with byte
// enables and 1-cycle registered reads, plus an MMIO window with a cycle
// counter and (when DMEM_CONSOLE_EN is defined) a console TX FIFO, its
// STATUS register and a saturating drop counter.
module mips_data_mem
   import mips_data_mem_pkg::*;
#(
   parameter int          ADDR_W     = 12,
   parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000,
   parameter int          FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic [31:0] mem_addr,
   input  logic        mem_read_en,
   input  logic [3:0]  mem_write_en,
   input  logic [31:0] mem_write_data,
   output logic [31:0] mem_read_data,
   output logic        con_valid,
   output logic [7:0]  con_data,
   input  logic        con_ready
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic [31:0]       ram [1 << ADDR_W];
   logic [ADDR_W-1:0] ram_idx;
   logic              mmio_hit;
   logic              ram_hit;
   mmio_reg_e         mmio_reg;
   logic [31:0]       cycle_cnt;
   logic [31:0]       status_rd;
   logic [31:0]       drops_rd;
   logic [31:0]       mmio_rdata;
   logic              unused_addr;

   assign mmio_hit = (mem_addr[31:16] == MMIO_BASE[31:16]);
   assign ram_hit  = ~mmio_hit;
   assign ram_idx  = mem_addr[ADDR_W+1:2];
   assign mmio_reg = mmio_reg_e'(mem_addr[3:2]);

   // Upper RAM address bits alias and the byte offset never faults.
   assign unused_addr = ^mem_addr;

   // RAM write: only the enabled byte lanes of the addressed word change.
   // NOTE: the RAM array has no reset so it can map onto block RAM; only
   // control state and the read register are reset.
   always_ff @(posedge clk) begin
      if (en && ram_hit) begin
         for (int lane = 0; lane < 4; lane++) begin
            if (mem_write_en[lane]) begin
               ram[ram_idx][lane*8 +: 8] <= mem_write_data[lane*8 +: 8];
            end
         end
      end
   end

   // Cycle counter advances on every enabled cycle and wraps.
   // NOTE: sequential state always uses <= so every register samples the
   // pre-edge values; this is also what makes read-during-write return old data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycle_cnt <= '0;
      end else if (en) begin
         cycle_cnt <= cycle_cnt + 32'd1;
      end
   end

`ifdef DMEM_CONSOLE_EN
   logic             mmio_wr;
   logic             push;
   logic             pop;
   logic             drop;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CNT_W-1:0] fifo_count;
   logic [7:0]       fifo_head;
   logic [31:0]      drops;

   assign mmio_wr = en & mmio_hit & (|mem_write_en);
   assign push    = mmio_wr & (mmio_reg == MMIO_CONDATA);
   assign pop     = ~fifo_empty & con_ready;
   assign drop    = push & fifo_full & ~pop;

   dmem_console_fifo #(
      .DEPTH  (FIFO_DEPTH),
      .DATA_W (8),
      .CNT_W  (CNT_W)
   ) u_console_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (mem_write_data[7:0]),
      .pop       (pop),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // Drop counter: saturates at all-ones, any write to DROPS clears it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drops <= '0;
      end else if (mmio_wr && (mmio_reg == MMIO_DROPS)) begin
         drops <= '0;
      end else if (drop && (drops != '1)) begin
         drops <= drops + 32'd1;
      end
   end

   assign con_valid = ~fifo_empty;
   assign con_data  = fifo_head;
   assign status_rd = status_word(STATUS_COUNT_W'(fifo_count), fifo_empty, fifo_full);
   assign drops_rd  = drops;
`else
   logic unused_console;

   assign con_valid      = 1'b0;
   assign con_data       = 8'h00;
   assign status_rd      = STATUS_NO_CONSOLE;
   assign drops_rd       = 32'h0;
   assign unused_console = con_ready | (FIFO_DEPTH == 0);
`endif

   // MMIO read mux; STATUS and CYCLE reflect their value at the request edge.
   // NOTE: every always_comb output gets a default first so no path can
   // infer a latch.
   always_comb begin
      mmio_rdata = 32'h0;
      case (mmio_reg)
         MMIO_CYCLE:   mmio_rdata = cycle_cnt;
         MMIO_STATUS:  mmio_rdata = status_rd;
         MMIO_CONDATA: mmio_rdata = 32'h0;
         MMIO_DROPS:   mmio_rdata = drops_rd;
         default:      mmio_rdata = 32'h0;
      endcase
   end

   // Read data register: captures on enabled read requests, holds otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_read_data <= '0;
      end else if (en && mem_read_en) begin
         mem_read_data <= mmio_hit ? mmio_rdata : ram[ram_idx];
      end
   end

endmodule
